// File: rtl/seg_disp_pkg.sv
// Shared segment codes, FSM state type and sizing helpers for the
// sequential seven-segment display path.
package seg_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Enough BCD nibbles to hold any WIDTH-bit binary value.
  function automatic int bcd_digits(input int width);
    return (width + 2) / 3;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_disp_ctrl_bin2bcd.sv
// Iterative shift-add-3 binary to BCD converter, one bit per clock.
// In hex mode the captured value is passed straight to FINISH unshifted.
module bin2bcd_seq
  import seg_disp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic                             hex_i,
  input  logic [WIDTH-1:0]                 value_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             hex_o,
  output logic [WIDTH-1:0]                 bin_o,
  output logic [4*bcd_digits(WIDTH)-1:0]   bcd_o
);

  localparam int BCD_DIGITS = bcd_digits(WIDTH);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hex_q, hex_d;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    bcd_adj_s = bcd_q;
    for (int n = 0; n < BCD_DIGITS; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        bcd_adj_s[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*n +: 4] = bcd_q[4*n +: 4];
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          shift_d = value_i;
          bcd_d   = {BCD_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          hex_d   = hex_i;
          state_d = hex_i ? ST_FINISH : ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        {bcd_d, shift_d} = {bcd_adj_s, shift_q} << 1'b1;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= {WIDTH{1'b0}};
      bcd_q   <= {BCD_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      hex_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_FINISH);
  assign hex_o  = hex_q;
  assign bin_o  = shift_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_disp_ctrl.sv
// Sequential seven-segment display controller: latches a value, converts it,
// and drives parallel segment buses plus a time-multiplexed scan output.
module seg_disp_ctrl
  import seg_disp_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        value_i,
  input  logic                    load_i,
  input  logic                    hex_mode_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overflow_o,
  output logic [7*NUM_DIGITS-1:0] seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              scan_seg_o
);

  localparam int BCD_W = 4 * bcd_digits(WIDTH);
  localparam int NIB_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 7 * NUM_DIGITS;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SEG_W-1:0]      SEG_POL  = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [6:0]            SCAN_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_POL   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic               conv_busy_s, conv_done_s, conv_hex_s;
  logic [WIDTH-1:0]   conv_bin_s;
  logic [BCD_W-1:0]   conv_bcd_s;

  logic [NIB_W-1:0]   nib_s;
  logic               ovf_s;
  logic [SEG_W-1:0]   seg_new_s;

  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            scan_seg_q, scan_seg_d;

  bin2bcd_seq #(
    .WIDTH(WIDTH)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (load_i),
    .hex_i   (hex_mode_i),
    .value_i (value_i),
    .busy_o  (conv_busy_s),
    .done_o  (conv_done_s),
    .hex_o   (conv_hex_s),
    .bin_o   (conv_bin_s),
    .bcd_o   (conv_bcd_s)
  );

  // Digit selection, overflow and leading-zero blanking; overflow keeps all digits lit.
  always_comb begin
    logic upper_zero;
    nib_s      = conv_hex_s ? NIB_W'(conv_bin_s) : NIB_W'(conv_bcd_s);
    ovf_s      = conv_hex_s ? |(conv_bin_s >> NIB_W) : |(conv_bcd_s >> NIB_W);
    upper_zero = 1'b1;
    seg_new_s  = {SEG_W{1'b0}};
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      upper_zero = upper_zero & (nib_s[4*d +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && !ovf_s && (d > 0) && upper_zero) begin
        seg_new_s[7*d +: 7] = SEG_BLANK;
      end else begin
        seg_new_s[7*d +: 7] = hex_to_seg(nib_s[4*d +: 4]);
      end
    end
  end

  // Display registers update only when a conversion finishes.
  always_comb begin
    seg_d  = seg_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (conv_done_s) begin
      seg_d  = seg_new_s ^ SEG_POL;
      ovf_d  = ovf_s;
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // Scan divider/index; an_o and scan_seg_o use next-state values so they stay aligned with seg_o.
  always_comb begin
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = DIV_W'(0);
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = IDX_W'(0);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
    end
    an_d       = (NUM_DIGITS'(1'b1) << idx_d) ^ AN_POL;
    scan_seg_d = seg_d[7*idx_d +: 7];
  end

  // Output and scan registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= SEG_POL;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      div_q      <= DIV_W'(0);
      idx_q      <= IDX_W'(0);
      an_q       <= AN_POL;
      scan_seg_q <= SCAN_POL;
    end else begin
      seg_q      <= seg_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      scan_seg_q <= scan_seg_d;
    end
  end

  assign busy_o     = conv_busy_s;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign seg_o      = seg_q;
  assign an_o       = an_q;
  assign scan_seg_o = scan_seg_q;

endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
- Sequential successor to the combinational BCD/seven-segment display path.
- Latches a WIDTH-bit binary value on a load strobe and converts it iteratively to BCD using shift-add-3 (double dabble), one bit per cycle.
- Drives NUM_DIGITS display digits in two forms: parallel segment buses, and a time-multiplexed scan output (segments plus anode select).
- Adds hex mode, leading-zero blanking, overflow flagging, configurable polarity and a busy/done handshake. Sits between the CPU datapath result register and the board displays.

Parameters:
- WIDTH, 32: input value width.
- NUM_DIGITS, 4: number of displayed digits (1..8).
- SCAN_DIV, 50000: clocks per digit in the scan output (>=1).
- BLANK_LZ, 1: 1 blanks leading zero digits; digit 0 is never blanked.
- SEG_ACTIVE_LOW, 1: 1 inverts seg_o and scan_seg_o.
- AN_ACTIVE_LOW, 1: 1 makes the active an_o bit 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- value_i  in  WIDTH  binary value, sampled on load.
- load_i  in  1  start conversion; accepted only when busy_o=0.
- hex_mode_i  in  1  sampled with load: 1 shows hex nibbles, 0 shows decimal.
- busy_o  out  1  conversion in progress.
- done_o  out  1  one-cycle pulse when the display registers are updated.
- overflow_o  out  1  value has more digits than NUM_DIGITS; held until the next completed load.
- seg_o  out  7*NUM_DIGITS  parallel segments; digit d occupies [7d+6:7d]; bit6=a ... bit0=g.
- an_o  out  NUM_DIGITS  one-hot scan digit select.
- scan_seg_o  out  7  segments of the digit currently selected by an_o.

Behaviour:
- Segment code, active-high, a..g = bit6..bit0:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, B=1F, C=4E, D=3D, E=4F, F=47
  - blank=00
  - Polarity inversion is applied after all other processing.
- Reset values:
  - busy_o=0, done_o=0, overflow_o=0.
  - Display registers are blank, so seg_o shows all segments off at the selected polarity.
  - Scan index=0, divider=0. an_o is all-inactive during the reset cycle, then selects digit 0.
- rst has priority over every other input, including a simultaneous load_i.
- FSM states: IDLE, CONV, FINISH.
  - IDLE: load_i=1 at edge k captures value_i into the shift register, clears the BCD register (BCD_DIGITS=(WIDTH+2)/3 nibbles) and the bit counter, and latches hex_mode_i.
    - Decimal: go to CONV.
    - Hex: go to FINISH.
  - CONV: at each edge, every BCD nibble >=5 gets +3, then {bcd, shift} shifts left by 1. After WIDTH shifts (edges k+1..k+WIDTH), go to FINISH.
  - FINISH: display registers load the low NUM_DIGITS digits, overflow_o is updated, done_o=1 for that one cycle, then return to IDLE.
- Latency from the load edge k:
  - Decimal: display and done_o update at edge k+WIDTH+1.
  - Hex: display and done_o update at edge k+1.
- busy_o=1 whenever the state is not IDLE.
- load_i while busy_o=1 is ignored: no queueing, no restart.
- Overflow:
  - Decimal: any nonzero BCD nibble at or above NUM_DIGITS.
  - Hex: any nonzero value bit at or above 4*NUM_DIGITS.
  - The low digits are still displayed.
- Blanking (BLANK_LZ=1): digit d>0 is blank if it and all higher displayed digits are zero. Overflow suppresses blanking.
- Reset mid-conversion: the conversion is abandoned, no done_o pulse, and the display is blank.
- Scan:
  - The divider counts 0..SCAN_DIV-1; on wrap, the index advances, going from NUM_DIGITS-1 back to 0.
  - an_o is one-hot on the index. scan_seg_o is registered together with an_o and always matches the selected digit of seg_o.
  - Scanning runs continuously and is independent of the FSM.

Decomposition:
- Package seg_disp_pkg holds:
  - the segment constants SEG_0..SEG_F and SEG_BLANK;
  - the hex_to_seg function;
  - the FSM state enum;
  - the BCD_DIGITS calculation.
- Sub-module bin2bcd_seq (parameter WIDTH) implements the iterative double dabble with a start/busy/done interface.
- The top level implements muxing, blanking, overflow detection, polarity and scanning.

Test Plan:
All scenarios use WIDTH=32, NUM_DIGITS=4, SCAN_DIV=4, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0.
- Decimal 1234: load 1234 (0x4D2), hex=0 -> done_o pulses 33 cycles after the load edge; seg_o digits 3..0 = 30,6D,79,33; overflow_o=0; busy_o high for 33 cycles.
- Blanking: load 7 -> digits 3..1 = 00, digit0 = 70. Then load 0 -> digits 3..1 = 00, digit0 = 7E.
- Overflow: load 123456 -> overflow_o=1, digits show 3456 = 79,33,5B,5F. Then load 42 -> overflow_o=0.
- Hex: load 0xBEEF, hex=1 -> done_o at load+1; digits = 1F,4F,4F,47.
- Handshake and reset:
  - load 99 during an active conversion of 1234 -> ignored; the display shows 1234.
  - rst at conversion cycle 10 -> busy_o=0, seg_o=0, no done_o.
- Scan: after reset, an_o = 0001,0010,0100,1000,0001, changing every 4 cycles; scan_seg_o equals seg_o of the selected digit on every cycle.
